day11_path_counter: RTL and testbench

Upstream stage of the day-11 solver: stores a DAG edge list streamed from the input parser, then computes path counts for seven programmed (source, target) node pairs by dynamic programming over the edge list. The seven 64-bit counts leave on the count_valid/count_last/count stream that feeds the day-11 result combiner, which takes part 1 from count 0 and part 2 from counts 1–6.

---
 rtl/day11_path_counter.sv | 248 ++++++++++++++++++++++++
 tb/tb_day11_path_counter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/day11_path_counter.sv
// Path counter for the day-11 solver: buffers a topologically sorted edge list and
// streams seven DP path counts. Define DAY11_EDGE_CHECK_EN to drop out-of-order edges.
module day11_path_counter #(
    parameter int NODE_BITS = 10,
    parameter int EDGE_BITS = 12
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 edge_valid,
    input  logic [NODE_BITS-1:0] edge_src,
    input  logic [NODE_BITS-1:0] edge_dst,
    input  logic                 edge_last,
    output logic                 edge_ready,
    input  logic                 query_we,
    input  logic [2:0]           query_idx,
    input  logic [NODE_BITS-1:0] query_src,
    input  logic [NODE_BITS-1:0] query_dst,
    input  logic                 start,
    output logic                 busy,
    output logic [63:0]          count,
    output logic                 count_valid,
    output logic                 count_last,
    input  logic                 count_ready,
    output logic                 order_err
);

    localparam int NODES = 1 << NODE_BITS;
    localparam int EDGES = 1 << EDGE_BITS;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_SEED,
        S_E_RD,
        S_S_RD,
        S_D_RD,
        S_WR,
        S_T_RD,
        S_T_LD,
        S_EMIT
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             query_q, query_d;
    logic [NODE_BITS-1:0]   clr_idx_q, clr_idx_d;
    logic [EDGE_BITS:0]     edge_idx_q, edge_idx_d, edge_idx_inc;
    logic [63:0]            src_val_q, src_val_d;
    logic [63:0]            count_q, count_d;

    logic [EDGE_BITS:0]     edge_cnt_q, edge_cnt_base;
    logic                   graph_loaded_q;
    logic                   order_err_q;
    logic                   edge_acc, edge_full, edge_bad, edge_store;

    logic [2*NODE_BITS-1:0] edge_mem [EDGES];
    logic [2*NODE_BITS-1:0] edge_rd_q;
    logic [63:0]            ways_mem [NODES];
    logic [63:0]            ways_rd_q;
    logic                   ways_we;
    logic [NODE_BITS-1:0]   ways_waddr, ways_raddr;
    logic [63:0]            ways_wdata;

    logic [NODE_BITS-1:0]   qsrc_q [7];
    logic [NODE_BITS-1:0]   qdst_q [7];
    logic [NODE_BITS-1:0]   rd_src, rd_dst, cur_src, cur_dst;

    assign busy       = (state_q != S_IDLE);
    assign edge_ready = !busy;
    assign edge_acc   = edge_valid && edge_ready;

    // The first edge after a completed graph begins a fresh list at address 0.
    assign edge_cnt_base = graph_loaded_q ? '0 : edge_cnt_q;
    assign edge_full     = edge_cnt_base[EDGE_BITS];

`ifdef DAY11_EDGE_CHECK_EN
    logic [NODE_BITS-1:0] prev_src_q;
    logic                 prev_valid_q;

    assign edge_bad = (edge_src >= edge_dst) ||
                      (prev_valid_q && !graph_loaded_q && (edge_src < prev_src_q));

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            prev_src_q   <= '0;
            prev_valid_q <= 1'b0;
        end else if (edge_acc) begin
            prev_src_q   <= edge_src;
            prev_valid_q <= 1'b1;
        end
    end
`else
    assign edge_bad = 1'b0;
`endif

    assign edge_store = edge_acc && !edge_full && !edge_bad;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            edge_cnt_q     <= '0;
            graph_loaded_q <= 1'b0;
            order_err_q    <= 1'b0;
        end else if (edge_acc) begin
            edge_cnt_q     <= edge_cnt_base + {{EDGE_BITS{1'b0}}, edge_store};
            graph_loaded_q <= edge_last;
            if (edge_full || edge_bad) begin
                order_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (edge_store) begin
            edge_mem[edge_cnt_base[EDGE_BITS-1:0]] <= {edge_src, edge_dst};
        end
        edge_rd_q <= edge_mem[edge_idx_q[EDGE_BITS-1:0]];
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < 7; i++) begin
                qsrc_q[i] <= '0;
                qdst_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (query_we && !busy && (query_idx == 3'(i))) begin
                    qsrc_q[i] <= query_src;
                    qdst_q[i] <= query_dst;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ways_we) begin
            ways_mem[ways_waddr] <= ways_wdata;
        end
        ways_rd_q <= ways_mem[ways_raddr];
    end

    assign rd_src  = edge_rd_q[2*NODE_BITS-1:NODE_BITS];
    assign rd_dst  = edge_rd_q[NODE_BITS-1:0];
    assign cur_src = qsrc_q[query_q];
    assign cur_dst = qdst_q[query_q];
    assign edge_idx_inc = edge_idx_q + {{EDGE_BITS{1'b0}}, 1'b1};

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= S_IDLE;
            query_q    <= '0;
            clr_idx_q  <= '0;
            edge_idx_q <= '0;
            src_val_q  <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            query_q    <= query_d;
            clr_idx_q  <= clr_idx_d;
            edge_idx_q <= edge_idx_d;
            src_val_q  <= src_val_d;
            count_q    <= count_d;
        end
    end

    // Each edge takes four cycles: fetch edge, read ways[src], read ways[dst], write sum.
    always_comb begin
        state_d    = state_q;
        query_d    = query_q;
        clr_idx_d  = clr_idx_q;
        edge_idx_d = edge_idx_q;
        src_val_d  = src_val_q;
        count_d    = count_q;
        ways_we    = 1'b0;
        ways_waddr = clr_idx_q;
        ways_wdata = '0;
        ways_raddr = rd_dst;
        case (state_q)
            S_IDLE: begin
                if (start && graph_loaded_q) begin
                    state_d   = S_CLR;
                    query_d   = '0;
                    clr_idx_d = '0;
                end
            end
            S_CLR: begin
                ways_we   = 1'b1;
                clr_idx_d = clr_idx_q + {{(NODE_BITS-1){1'b0}}, 1'b1};
                if (clr_idx_q == {NODE_BITS{1'b1}}) begin
                    state_d = S_SEED;
                end
            end
            S_SEED: begin
                ways_we    = 1'b1;
                ways_waddr = cur_src;
                ways_wdata = 64'd1;
                edge_idx_d = '0;
                state_d    = (edge_cnt_q == '0) ? S_T_RD : S_E_RD;
            end
            S_E_RD: begin
                state_d = S_S_RD;
            end
            S_S_RD: begin
                ways_raddr = rd_src;
                state_d    = S_D_RD;
            end
            S_D_RD: begin
                src_val_d  = ways_rd_q;
                ways_raddr = rd_dst;
                state_d    = S_WR;
            end
            S_WR: begin
                ways_we    = 1'b1;
                ways_waddr = rd_dst;
                ways_wdata = ways_rd_q + src_val_q;
                edge_idx_d = edge_idx_inc;
                state_d    = (edge_idx_inc == edge_cnt_q) ? S_T_RD : S_E_RD;
            end
            S_T_RD: begin
                ways_raddr = cur_dst;
                state_d    = S_T_LD;
            end
            S_T_LD: begin
                count_d = ways_rd_q;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (count_ready) begin
                    if (query_q == 3'd6) begin
                        state_d = S_IDLE;
                    end else begin
                        query_d   = query_q + 3'd1;
                        clr_idx_d = '0;
                        state_d   = S_CLR;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign count       = count_q;
    assign count_valid = (state_q == S_EMIT);
    assign count_last  = (state_q == S_EMIT) && (query_q == 3'd6);
    assign order_err   = order_err_q;

endmodule

// File: tb/tb_day11_path_counter.sv
// Directed and randomized bench for day11_path_counter; reference counts come from a
// backward path-sum over the edge list (paths(u) = sum of paths(v) over edges u->v).
module tb_day11_path_counter;

    localparam int NB    = 8;
    localparam int EB    = 9;
    localparam int NODES = 1 << NB;
    localparam int LIMIT = 4000;

    typedef logic [NB-1:0] node_t;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        edge_valid = 1'b0;
    logic        edge_last = 1'b0;
    logic        query_we = 1'b0;
    logic        start = 1'b0;
    logic        count_ready = 1'b0;
    node_t       edge_src = '0;
    node_t       edge_dst = '0;
    node_t       query_src = '0;
    node_t       query_dst = '0;
    logic [2:0]  query_idx = '0;
    logic        edge_ready, busy, count_valid, count_last, order_err;
    logic [63:0] count;

    int checks = 0;
    int errors = 0;
    node_t e_src[$];
    node_t e_dst[$];
    int n_stored = 0;
    longint unsigned exp_cnt [7];
    int qs [7];
    int qd [7];

    day11_path_counter #(.NODE_BITS(NB), .EDGE_BITS(EB)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .edge_valid  (edge_valid),
        .edge_src    (edge_src),
        .edge_dst    (edge_dst),
        .edge_last   (edge_last),
        .edge_ready  (edge_ready),
        .query_we    (query_we),
        .query_idx   (query_idx),
        .query_src   (query_src),
        .query_dst   (query_dst),
        .start       (start),
        .busy        (busy),
        .count       (count),
        .count_valid (count_valid),
        .count_last  (count_last),
        .count_ready (count_ready),
        .order_err   (order_err)
    );

    initial begin
        forever #5 clock = ~clock;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_edge_ready"}, 64'(edge_ready), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_count"}, count, 64'd0);
        chk({tag, "_count_valid"}, 64'(count_valid), 64'd0);
        chk({tag, "_count_last"}, 64'(count_last), 64'd0);
        chk({tag, "_order_err"}, 64'(order_err), 64'd0);
    endtask

    task automatic finish_now();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            qs[i] = 0;
            qd[i] = 0;
        end
    endtask

    task automatic wait_valid(inout int n);
        while (count_valid !== 1'b1 && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) begin
            checks++;
            errors++;
            $display("FAIL timeout count_valid observed=0 expected=1");
            finish_now();
        end
    endtask

    task automatic load_graph();
        for (int i = 0; i < e_src.size(); i++) begin
            edge_valid = 1'b1;
            edge_src   = e_src[i];
            edge_dst   = e_dst[i];
            edge_last  = (i == e_src.size() - 1);
            tick();
        end
        edge_valid = 1'b0;
        edge_last  = 1'b0;
        n_stored   = e_src.size();
    endtask

    task automatic set_query(input int i, input int s, input int d);
        query_we  = 1'b1;
        query_idx = 3'(i);
        query_src = node_t'(s);
        query_dst = node_t'(d);
        tick();
        query_we  = 1'b0;
        qs[i] = s;
        qd[i] = d;
    endtask

    function automatic longint unsigned ref_paths(input int s, input int t);
        longint unsigned p [NODES];
        for (int u = 0; u < NODES; u++) p[u] = 0;
        if (t < s) return 0;
        p[t] = 1;
        for (int u = t - 1; u >= s; u--) begin
            for (int k = 0; k < e_src.size(); k++) begin
                if (int'(e_src[k]) == u) p[u] += p[int'(e_dst[k])];
            end
        end
        return p[s];
    endfunction

    task automatic model_all();
        for (int i = 0; i < 7; i++) exp_cnt[i] = ref_paths(qs[i], qd[i]);
    endtask

    task automatic add_edge(input int s, input int d);
        e_src.push_back(node_t'(s));
        e_dst.push_back(node_t'(d));
    endtask

    task automatic build_plan();
        e_src.delete();
        e_dst.delete();
        add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3); add_edge(3, 4);
    endtask

    task automatic plan_queries();
        set_query(0, 0, 4); set_query(1, 0, 3); set_query(2, 1, 4); set_query(3, 4, 0);
        set_query(4, 2, 2); set_query(5, 1, 2); set_query(6, 0, 1);
        exp_cnt[0] = 2; exp_cnt[1] = 2; exp_cnt[2] = 1; exp_cnt[3] = 0;
        exp_cnt[4] = 1; exp_cnt[5] = 0; exp_cnt[6] = 1;
    endtask

    task automatic build_ladder(input int nd);
        e_src.delete();
        e_dst.delete();
        for (int d = 0; d < nd; d++) begin
            add_edge(3 * d, 3 * d + 1);
            add_edge(3 * d, 3 * d + 2);
            add_edge(3 * d + 1, 3 * d + 3);
            add_edge(3 * d + 2, 3 * d + 3);
        end
    endtask

    task automatic run_queries(input int stall, input bit extra_start, input int stop_q);
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_rise", 64'(busy), 64'd1);
        for (int q = 0; q < 7; q++) begin
            if (q == stop_q) return;
            n = 0;
            if (extra_start && q == 2) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                n = 1;
            end
            wait_valid(n);
            chk("latency", 64'(n), 64'(NODES + 3 + 4 * n_stored));
            chk("count", count, exp_cnt[q]);
            chk("count_last", 64'(count_last), 64'(q == 6));
            for (int s = 0; s < stall; s++) begin
                tick();
                chk("stall_valid", 64'(count_valid), 64'd1);
                chk("stall_count", count, exp_cnt[q]);
                chk("stall_last", 64'(count_last), 64'(q == 6));
            end
            $display("beat q=%0d count=%0h last=%0b", q, count, count_last);
            count_ready = 1'b1;
            tick();
            count_ready = 1'b0;
        end
        chk("busy_fall", 64'(busy), 64'd0);
        repeat (3) begin
            tick();
            chk("no_extra_beat", 64'(count_valid), 64'd0);
        end
    endtask

    initial begin
        int packed_e[$];
        int a, b;

        // Reset values
        repeat (2) tick();
        chk_reset("reset");
        clear_n = 1'b1;
        tick();
        chk_reset("post_reset");

        // start with no graph loaded is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_no_graph", 64'(busy), 64'd0);
        tick();
        chk("start_no_graph2", 64'(busy), 64'd0);

        // Reference graph, then a rerun with back-pressure and a stray start
        build_plan();
        load_graph();
        plan_queries();
        run_queries(0, 1'b0, 7);
        run_queries(10, 1'b1, 7);

        // Random DAG (also replaces the previous graph without reset)
        e_src.delete();
        e_dst.delete();
        for (int k = 0; k < 48; k++) begin
            a = int'($urandom_range(0, 38));
            b = int'($urandom_range(a + 1, 39));
            packed_e.push_back(a * 256 + b);
        end
        packed_e.sort();
        foreach (packed_e[k]) add_edge(packed_e[k] / 256, packed_e[k] % 256);
        load_graph();
        for (int i = 0; i < 5; i++) begin
            a = int'($urandom_range(0, 39));
            set_query(i, a, int'($urandom_range(a, 39)));
        end
        a = int'($urandom_range(1, 39));
        set_query(5, a, int'($urandom_range(0, a - 1)));
        set_query(6, int'($urandom_range(0, 39)), int'($urandom_range(0, 39)));
        model_all();
        run_queries(2, 1'b0, 7);

        // Ladders: 64 diamonds wrap to 0, 63 diamonds give 2^63
        build_ladder(64);
        load_graph();
        set_query(0, 0, 192); set_query(1, 0, 3); set_query(2, 3, 192); set_query(3, 1, 192);
        set_query(4, 6, 12); set_query(5, 192, 192); set_query(6, 190, 3);
        model_all();
        exp_cnt[0] = 64'd0;
        run_queries(0, 1'b0, 7);
        build_ladder(63);
        load_graph();
        set_query(0, 0, 189);
        model_all();
        exp_cnt[0] = 64'h8000_0000_0000_0000;
        run_queries(0, 1'b0, 7);

        // Abort during query 3
        build_plan();
        load_graph();
        plan_queries();
        run_queries(0, 1'b0, 3);
        repeat (20) tick();
        clear_n = 1'b0;
        #1;
        chk_reset("abort");
        tick();
        chk_reset("abort_hold");
        clear_n = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            qs[i] = 0;
            qd[i] = 0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_after_abort", 64'(busy), 64'd0);
        tick();
        chk("start_after_abort2", 64'(busy), 64'd0);

        // Reloaded graph with the reset (all-zero) query table: every count is 1
        load_graph();
        model_all();
        run_queries(0, 1'b0, 7);

        // Order check: 2->1 then 0->1
        do_reset();
        e_src.delete();
        e_dst.delete();
        add_edge(2, 1);
        add_edge(0, 1);
        load_graph();
        set_query(0, 0, 1);
        for (int i = 1; i < 7; i++) exp_cnt[i] = 64'd1;
`ifdef DAY11_EDGE_CHECK_EN
        chk("order_err_set", 64'(order_err), 64'd1);
        n_stored   = 0;
        exp_cnt[0] = 64'd0;
`else
        chk("order_err_clear", 64'(order_err), 64'd0);
        n_stored   = 2;
        exp_cnt[0] = 64'd1;
`endif
        run_queries(0, 1'b0, 7);

        // Capacity overflow: the 513th edge is dropped and flags order_err
        do_reset();
        for (int i = 0; i < 513; i++) begin
            edge_valid = 1'b1;
            edge_src   = node_t'(0);
            edge_dst   = node_t'(1);
            edge_last  = (i == 512);
            tick();
            if (i == 511) chk("cap_full_ok", 64'(order_err), 64'd0);
        end
        edge_valid = 1'b0;
        edge_last  = 1'b0;
        chk("cap_overflow", 64'(order_err), 64'd1);

        finish_now();
    end

endmodule
